// File: rtl/wb_stage.sv
// M/W pipeline register with write-back decode.
// Drives the register file write port and W forwarding.
module wb_stage #(
  parameter int RA_REG = 31,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [31:0]      ir_m,
  input  logic [31:0]      pc4_m,
  input  logic [31:0]      alu_m,
  input  logic [31:0]      dm_rd_m,
  input  logic             bgezal_m,
  input  logic             movz_m,
  output logic [31:0]      ir_w,
  output logic [31:0]      pc4_w,
  output logic             bgezal_w,
  output logic             movz_w,
  output logic             regwrite_w,
  output logic [4:0]       wreg,
  output logic [31:0]      wdata,
  output logic [CNT_W-1:0] retired
);

  localparam logic [4:0] RA = 5'(RA_REG);

  localparam logic [5:0] OP_SPEC = 6'b000000;
  localparam logic [5:0] OP_RIMM = 6'b000001;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LHU  = 6'b100101;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_MOVZ = 6'b001010;

  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] pc8;
  logic        we_d;
  logic [4:0]  dst_d;
  logic [31:0] wd_d;

  assign op  = ir_m[31:26];
  assign fn  = ir_m[5:0];
  assign rt  = ir_m[20:16];
  assign rd  = ir_m[15:11];
  assign pc8 = pc4_m + 32'd4;

  // Halfword lanes: alu_m[0] is ignored.
  assign ld_h = alu_m[1] ? dm_rd_m[31:16]
                         : dm_rd_m[15:0];

  // Byte lane select from the low address bits.
  always_comb begin
    ld_b = dm_rd_m[7:0];
    case (alu_m[1:0])
      2'd0: ld_b = dm_rd_m[7:0];
      2'd1: ld_b = dm_rd_m[15:8];
      2'd2: ld_b = dm_rd_m[23:16];
      2'd3: ld_b = dm_rd_m[31:24];
      default: ld_b = dm_rd_m[7:0];
    endcase
  end

  // Write enable, destination and data from the M instruction.
  // op[2] distinguishes the unsigned load variants.
  always_comb begin
    we_d  = 1'b0;
    dst_d = '0;
    wd_d  = '0;
    unique case (1'b1)
      op == OP_SPEC && (fn == F_ADDU ||
                        fn == F_SUBU ||
                        fn == F_SRAV): begin
        we_d  = 1'b1;
        dst_d = rd;
        wd_d  = alu_m;
      end
      op == OP_SPEC && fn == F_MOVZ: begin
        we_d  = movz_m;
        dst_d = rd;
        wd_d  = alu_m;
      end
      op == OP_ORI || op == OP_LUI: begin
        we_d  = 1'b1;
        dst_d = rt;
        wd_d  = alu_m;
      end
      op == OP_LW: begin
        we_d  = 1'b1;
        dst_d = rt;
        wd_d  = dm_rd_m;
      end
      op == OP_LB || op == OP_LBU: begin
        we_d  = 1'b1;
        dst_d = rt;
        wd_d  = {{24{ld_b[7] & ~op[2]}}, ld_b};
      end
      op == OP_LH || op == OP_LHU: begin
        we_d  = 1'b1;
        dst_d = rt;
        wd_d  = {{16{ld_h[15] & ~op[2]}}, ld_h};
      end
      op == OP_JAL: begin
        we_d  = 1'b1;
        dst_d = RA;
        wd_d  = pc8;
      end
      op == OP_RIMM && rt == RT_BGEZAL: begin
        we_d  = bgezal_m;
        dst_d = RA;
        wd_d  = pc8;
      end
      default: begin
        we_d  = 1'b0;
      end
    endcase
    if (!we_d) begin
      dst_d = '0;
      wd_d  = '0;
    end
  end

  // W registers: reset, then flush, then advance, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_w       <= '0;
      pc4_w      <= '0;
      bgezal_w   <= 1'b0;
      movz_w     <= 1'b0;
      regwrite_w <= 1'b0;
      wreg       <= '0;
      wdata      <= '0;
      retired    <= '0;
    end else if (clr) begin
      ir_w       <= '0;
      pc4_w      <= '0;
      bgezal_w   <= 1'b0;
      movz_w     <= 1'b0;
      regwrite_w <= 1'b0;
      wreg       <= '0;
      wdata      <= '0;
    end else if (en) begin
      ir_w       <= ir_m;
      pc4_w      <= pc4_m;
      bgezal_w   <= bgezal_m;
      movz_w     <= movz_m;
      regwrite_w <= we_d;
      wreg       <= dst_d;
      wdata      <= wd_d;
      if (ir_m != '0) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- M/W pipeline register plus write-back generator: latches the memory-stage instruction and results on each rising clock edge.
- Decodes register-write enable and destination, extends load data, selects write data.
- Outputs drive the register file write port (ir_w, pc4_w, bgezal_w, movz_w, wreg, wdata) and the W-stage forwarding path.
- Keeps a retired-instruction counter for trace/debug.

Parameters:
- RA_REG, 31, destination register for jal/bgezal link.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- en  input  1  advance enable; 0 holds all W registers
- clr  input  1  synchronous flush; loads a bubble
- ir_m  input  32  M-stage instruction
- pc4_m  input  32  M-stage PC+4
- alu_m  input  32  M-stage ALU result / memory address / rs value for movz
- dm_rd_m  input  32  raw aligned word read from data memory, combinational in M
- bgezal_m  input  1  bgezal condition (rs >= 0) resolved earlier
- movz_m  input  1  movz condition (rt == 0) resolved earlier
- ir_w  output  32  registered instruction
- pc4_w  output  32  registered PC+4
- bgezal_w  output  1  registered bgezal condition
- movz_w  output  1  registered movz condition
- regwrite_w  output  1  register write enable for W instruction
- wreg  output  5  destination register; 0 when regwrite_w=0
- wdata  output  32  write data
- retired  output  CNT_W  count of non-bubble instructions entering W

Behaviour:
- Reset:
  - All outputs and state go to 0 asynchronously on reset=1, independent of clk.
  - reset takes priority over clr and en.
- Latency: 1 cycle. Every output is a register; wreg, wdata and regwrite_w are computed from M-side inputs before the register, so they are stable from the rising edge. The register file samples them on the falling edge.
- Update priority on the rising edge (reset=0):
  - clr=1: load a bubble (ir=0, pc4=0, flags=0, regwrite_w=0, wreg=0, wdata=0); retired is unchanged. clr beats en.
  - Otherwise en=1: load the new values.
  - Otherwise: hold every register.
- Decode (op = ir[31:26], func = ir[5:0], rt = ir[20:16], rd = ir[15:11]):
  - addu 000000/100001, subu 000000/100011, srav 000000/000111: rd <- alu_m.
  - movz 000000/001010: rd <- alu_m, write only if movz_m=1.
  - ori 001101, lui 001111: rt <- alu_m.
  - lw 100011: rt <- dm_rd_m.
  - lb 100000, lbu 100100: byte dm_rd_m[8*a+7:8*a] with a = alu_m[1:0], sign- or zero-extended.
  - lh 100001, lhu 100101: halfword selected by alu_m[1] (alu_m[0] ignored), sign- or zero-extended.
  - jal 000011: RA_REG <- pc4_m+4 (delay slot, so PC+8).
  - bgezal op 000001 with rt 10001: RA_REG <- pc4_m+4, write only if bgezal_m=1.
  - All other encodings, including nop 0x00000000: regwrite_w=0.
- Register zero: if the decoded destination is 0, regwrite_w stays asserted per decode so the write trace stays complete; wreg=0 and the register file discards the data.
- Disabled writes: when regwrite_w=0, wreg=0 and wdata=0, so forwarding compares never match.
- Arithmetic: pc4_m+4 is 32-bit modulo; 0xFFFFFFFC+4 wraps to 0.
- retired:
  - Increments by 1 on each en=1, clr=0 edge with ir_m != 0.
  - Wraps modulo 2^CNT_W.
  - Holds when en=0.

Test Plan:
- Reset mid-stream: lw latched, assert reset between edges -> all outputs 0 immediately, retired=0, before the next edge.
- lb/lbu sweep: dm_rd_m=0x80FF7F01, ir lb with alu_m[1:0]=3 -> wdata=0xFFFFFF80; lbu same address -> 0x00000080; lb with alu_m[1:0]=1 -> 0x0000007F.
- lh/lhu: dm_rd_m=0x8001FFFE, lh with alu_m=0x...2 -> 0xFFFF8001; lhu with alu_m=0x...0 -> 0x0000FFFE.
- jal with pc4_m=0x00003010 -> regwrite_w=1, wreg=31, wdata=0x00003014. bgezal with bgezal_m=0 -> regwrite_w=0, wreg=0, wdata=0, ir_w still latched.
- movz with movz_m=1, rd=5, alu_m=0x1234 -> wreg=5, wdata=0x1234. With movz_m=0 -> regwrite_w=0. addu with rd=0 -> regwrite_w=1, wreg=0.
- Control priority: en=0 for 3 cycles -> outputs and retired frozen. clr=1 with en=1 and ir_m=addu -> bubble, retired unchanged. 4 non-nop instructions plus 2 nops -> retired +4.
